// File: rtl/sap_output_bcd_register.sv
// SAP output register with a multi-cycle double-dabble binary-to-BCD converter.
// Raw value mirrors immediately; BCD, sign, blanking and overflow update together on completion.
module sap_output_bcd_register #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      DATA,
  input  logic                  latch,
  input  logic                  signed_mode,
  output logic [WIDTH-1:0]      REG_OUT,
  output logic [4*DIGITS-1:0]   DEC_OUT,
  output logic                  NEG,
  output logic [DIGITS-1:0]     BLANK,
  output logic                  OVF,
  output logic                  busy,
  output logic                  done
);

  localparam int                BW        = 4 * DIGITS;
  localparam int                CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     LAST_ITER = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [WIDTH-1:0]  mag_r;
  logic [BW-1:0]     bcd_r;
  logic [CW-1:0]     cnt_r;
  logic              ovf_r;
  logic              sign_r;
  logic              nz_r;
  logic [WIDTH-1:0]  pend_data_r;
  logic              pend_signed_r;
  logic              pend_valid_r;

  logic              start_s;
  logic [WIDTH-1:0]  job_data_s;
  logic              job_signed_s;
  logic              job_neg_s;
  logic [WIDTH-1:0]  job_mag_s;
  logic [BW-1:0]     bcd_adj_s;
  logic [DIGITS-1:0] blank_s;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Digit i is blanked when it and every digit above it are zero; digit 0 is always shown.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] b);
    logic [DIGITS-1:0] r;
    logic              zero_above;
    zero_above = 1'b1;
    r          = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (b[4*i +: 4] == 4'd0);
      r[i]       = (i != 0) ? zero_above : 1'b0;
    end
    return r;
  endfunction

  assign busy = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, job selection and per-iteration datapath terms.
  always_comb begin
    state_nx_s   = state_r;
    start_s      = 1'b0;
    job_data_s   = DATA;
    job_signed_s = signed_mode;
    case (state_r)
      IDLE: begin
        if (latch) begin
          start_s    = 1'b1;
          state_nx_s = CONV;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONV: begin
        if (cnt_r == LAST_ITER) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = CONV;
        end
      end
      FIN: begin
        if (latch) begin
          start_s    = 1'b1;
          state_nx_s = CONV;
        end else if (pend_valid_r) begin
          start_s      = 1'b1;
          job_data_s   = pend_data_r;
          job_signed_s = pend_signed_r;
          state_nx_s   = CONV;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    job_neg_s = job_signed_s & job_data_s[WIDTH-1];
    if (job_neg_s) begin
      job_mag_s = ~job_data_s + WIDTH'(1);
    end else begin
      job_mag_s = job_data_s;
    end
    bcd_adj_s = add3(bcd_r);
    blank_s   = blank_of(bcd_r);
  end

  // Conversion datapath, pending slot and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      REG_OUT       <= '0;
      DEC_OUT       <= '0;
      NEG           <= 1'b0;
      BLANK         <= BLANK_RST;
      OVF           <= 1'b0;
      done          <= 1'b0;
      mag_r         <= '0;
      bcd_r         <= '0;
      cnt_r         <= '0;
      ovf_r         <= 1'b0;
      sign_r        <= 1'b0;
      nz_r          <= 1'b0;
      pend_data_r   <= '0;
      pend_signed_r <= 1'b0;
      pend_valid_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (latch) begin
        REG_OUT <= DATA;
      end
      if (start_s) begin
        mag_r  <= job_mag_s;
        sign_r <= job_neg_s;
        nz_r   <= |job_data_s;
        bcd_r  <= '0;
        ovf_r  <= 1'b0;
        cnt_r  <= '0;
      end else if (state_r == CONV) begin
        bcd_r <= {bcd_adj_s[BW-2:0], mag_r[WIDTH-1]};
        mag_r <= {mag_r[WIDTH-2:0], 1'b0};
        ovf_r <= ovf_r | bcd_adj_s[BW-1];
        cnt_r <= cnt_r + CW'(1);
      end
      // A latch on the completion edge starts directly, so the slot is always emptied there.
      if (state_r == FIN) begin
        DEC_OUT      <= bcd_r;
        NEG          <= sign_r & nz_r;
        OVF          <= ovf_r;
        BLANK        <= blank_s;
        done         <= 1'b1;
        pend_valid_r <= 1'b0;
      end else if (latch && (state_r != IDLE)) begin
        pend_data_r   <= DATA;
        pend_signed_r <= signed_mode;
        pend_valid_r  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sap_output_bcd_register.sv
// Directed, table-driven bench for sap_output_bcd_register (8-bit and 16-bit instances).
module tb_sap_output_bcd_register;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data8;
  logic        latch8, sm8;
  logic [7:0]  reg8;
  logic [15:0] dec8;
  logic        neg8, ovf8, busy8, done8;
  logic [3:0]  blank8;
  logic [15:0] data16;
  logic        latch16, sm16;
  logic [15:0] reg16;
  logic [15:0] dec16;
  logic        neg16, ovf16, busy16, done16;
  logic [3:0]  blank16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sap_output_bcd_register #(.WIDTH(8), .DIGITS(4)) dut8 (
    .clk(clk), .reset(reset), .DATA(data8), .latch(latch8), .signed_mode(sm8),
    .REG_OUT(reg8), .DEC_OUT(dec8), .NEG(neg8), .BLANK(blank8), .OVF(ovf8),
    .busy(busy8), .done(done8));

  sap_output_bcd_register #(.WIDTH(16), .DIGITS(4)) dut16 (
    .clk(clk), .reset(reset), .DATA(data16), .latch(latch16), .signed_mode(sm16),
    .REG_OUT(reg16), .DEC_OUT(dec16), .NEG(neg16), .BLANK(blank16), .OVF(ovf16),
    .busy(busy16), .done(done16));

  typedef struct {
    logic        wide;
    logic [15:0] data;
    logic        sm;
    logic [15:0] dec;
    logic        neg;
    logic [3:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Latch one value, count edges to done, then compare every output.
  task automatic run_job(input vec_t v);
    int   n;
    logic busy_ok;
    int   lat;
    @(negedge clk);
    if (v.wide) begin
      latch16 = 1'b1; data16 = v.data; sm16 = v.sm;
    end else begin
      latch8 = 1'b1; data8 = v.data[7:0]; sm8 = v.sm;
    end
    @(negedge clk);
    latch8  = 1'b0;
    latch16 = 1'b0;
    check("reg_out", v.wide ? {16'd0, reg16} : {24'd0, reg8},
          v.wide ? {16'd0, v.data} : {24'd0, v.data[7:0]});
    n       = 0;
    busy_ok = 1'b1;
    lat     = -1;
    while (n < 40) begin
      if ((v.wide ? done16 : done8) === 1'b1) begin
        lat = n;
        break;
      end
      if ((v.wide ? busy16 : busy8) !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("latency", lat, v.wide ? 32'd17 : 32'd9);
    check("busy_during", {31'd0, busy_ok}, 32'd1);
    check("dec_out", v.wide ? {16'd0, dec16} : {16'd0, dec8}, {16'd0, v.dec});
    check("neg", {31'd0, v.wide ? neg16 : neg8}, {31'd0, v.neg});
    check("blank", {28'd0, v.wide ? blank16 : blank8}, {28'd0, v.blank});
    check("ovf", {31'd0, v.wide ? ovf16 : ovf8}, {31'd0, v.ovf});
    check("busy_after", {31'd0, v.wide ? busy16 : busy8}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, v.wide ? done16 : done8}, 32'd0);
  endtask

  task automatic check_reset8(input string tag);
    check({tag, "_reg"},   {24'd0, reg8},   32'd0);
    check({tag, "_dec"},   {16'd0, dec8},   32'd0);
    check({tag, "_blank"}, {28'd0, blank8}, 32'hE);
    check({tag, "_flags"}, {28'd0, neg8, ovf8, busy8, done8}, 32'd0);
  endtask

  initial begin
    int   n;
    int   done_cnt;
    int   done_n[2];
    logic [15:0] done_dec[2];
    logic busy_gap, seen7, late_done;

    vecs[0] = '{1'b0, 16'd255,   1'b0, 16'h0255, 1'b0, 4'b1000, 1'b0};
    vecs[1] = '{1'b0, 16'h0080,  1'b1, 16'h0128, 1'b1, 4'b1000, 1'b0};
    vecs[2] = '{1'b0, 16'h00FF,  1'b1, 16'h0001, 1'b1, 4'b1110, 1'b0};
    vecs[3] = '{1'b0, 16'h007F,  1'b1, 16'h0127, 1'b0, 4'b1000, 1'b0};
    vecs[4] = '{1'b0, 16'h0000,  1'b1, 16'h0000, 1'b0, 4'b1110, 1'b0};
    vecs[5] = '{1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 4'b1110, 1'b0};
    vecs[6] = '{1'b0, 16'h0085,  1'b1, 16'h0123, 1'b1, 4'b1000, 1'b0};
    vecs[7] = '{1'b0, 16'h0080,  1'b0, 16'h0128, 1'b0, 4'b1000, 1'b0};
    vecs[8] = '{1'b1, 16'd65535, 1'b0, 16'h5535, 1'b0, 4'b0000, 1'b1};
    vecs[9] = '{1'b1, 16'd9999,  1'b0, 16'h9999, 1'b0, 4'b0000, 1'b0};

    reset = 1'b1; latch8 = 1'b0; latch16 = 1'b0;
    data8 = 8'd0; data16 = 16'd0; sm8 = 1'b0; sm16 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset8("rst8");
    check("rst16_blank", {28'd0, blank16}, 32'hE);

    for (int i = 0; i < 10; i++) run_job(vecs[i]);

    // Pending overwrite: 42 at edge 0, 7 at edge 3, 99 at edge 5.
    @(negedge clk);
    latch8 = 1'b1; data8 = 8'd42; sm8 = 1'b0;
    done_cnt = 0; busy_gap = 1'b0; seen7 = 1'b0; late_done = 1'b0;
    done_n[0] = -1; done_n[1] = -1; done_dec[0] = 16'd0; done_dec[1] = 16'd0;
    for (n = 0; n <= 22; n++) begin
      @(negedge clk);
      latch8 = 1'b0;
      if (n == 0) check("pend_reg42", {24'd0, reg8}, 32'd42);
      if (n == 2) begin latch8 = 1'b1; data8 = 8'd7; end
      if (n == 3) check("pend_reg7", {24'd0, reg8}, 32'd7);
      if (n == 4) begin latch8 = 1'b1; data8 = 8'd99; end
      if (n == 5) check("pend_reg99", {24'd0, reg8}, 32'd99);
      if (n <= 17 && busy8 !== 1'b1) busy_gap = 1'b1;
      if (dec8 == 16'h0007) seen7 = 1'b1;
      if (done8 === 1'b1) begin
        if (done_cnt < 2) begin
          done_n[done_cnt]   = n;
          done_dec[done_cnt] = dec8;
        end else begin
          late_done = 1'b1;
        end
        done_cnt++;
      end
    end
    check("pend_done1_edge", done_n[0], 32'd9);
    check("pend_done1_dec", {16'd0, done_dec[0]}, 32'h42);
    check("pend_done2_edge", done_n[1], 32'd18);
    check("pend_done2_dec", {16'd0, done_dec[1]}, 32'h99);
    check("pend_extra_done", {31'd0, late_done}, 32'd0);
    check("pend_busy_gap", {31'd0, busy_gap}, 32'd0);
    check("pend_seen7", {31'd0, seen7}, 32'd0);
    check("pend_idle", {31'd0, busy8}, 32'd0);

    // Reset at edge 4 of a conversion aborts it, including a pending job.
    @(negedge clk);
    latch8 = 1'b1; data8 = 8'd200; sm8 = 1'b0;
    late_done = 1'b0;
    for (n = 0; n <= 30; n++) begin
      @(negedge clk);
      latch8 = 1'b0;
      if (n == 1) begin latch8 = 1'b1; data8 = 8'd33; end
      if (n == 3) reset = 1'b1;
      if (n == 4) begin
        check_reset8("midrst");
        reset = 1'b0;
      end
      if (n >= 4 && done8 !== 1'b0) late_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, late_done}, 32'd0);
    check("midrst_dec", {16'd0, dec8}, 32'd0);

    // Reset dominates a simultaneous latch.
    @(negedge clk);
    reset = 1'b1; latch8 = 1'b1; data8 = 8'd77;
    @(negedge clk);
    reset = 1'b0; latch8 = 1'b0;
    check("rst_vs_latch_reg", {24'd0, reg8}, 32'd0);
    check("rst_vs_latch_busy", {31'd0, busy8}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
